// File: rtl/sad_pkg.sv
// sad_pkg: shared types and helpers
// for the parametrised SAD pipe.
package sad_pkg;

  typedef struct packed {
    logic vld;
    logic acc;
    logic last;
  } sb_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int rw_of(
    input int w,
    input int np
  );
    return w + clog2(np);
  endfunction

  function automatic int aw_of(
    input int w,
    input int np,
    input int a
  );
    return rw_of(w, np) + a;
  endfunction

  // bit offset of tree level l in the
  // flat bus holding every level's terms
  function automatic int lvl_off(
    input int w,
    input int np,
    input int l
  );
    int o;
    o = 0;
    for (int j = 0; j < l; j++)
      o += (np >> j) * (w + j);
    return o;
  endfunction

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] m
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, m}) ? m : s[31:0];
  endfunction

  function automatic logic sat_ovf(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] m
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s > {1'b0, m};
  endfunction

endpackage

// File: rtl/sad_pipe_stage.sv
// sad_pipe_stage: one pipeline register
// with a valid bit and load logic.
module sad_pipe_stage
  import sad_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  input  sb_t           si,
  input  logic          dn_ld,
  output logic [DW-1:0] q,
  output sb_t           so
);

  logic ld;

  assign ld = !so.vld || dn_ld;

  // sideband follows each load; data only moves with a valid beat
  always_ff @(posedge clk) begin
    if (rst) begin
      q  <= '0;
      so <= '0;
    end else if (ld) begin
      so <= si;
      if (si.vld) q <= d;
    end
  end

endmodule

// File: rtl/sad_pipe_n.sv
// sad_pipe_n: NP-lane SAD with adder tree
// and block accumulate, valid/ready both sides.
module sad_pipe_n
  import sad_pkg::*;
#(
  parameter int W        = 8,
  parameter int NP       = 2,
  parameter int ACC_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [NP*W-1:0] x,
  input  logic [NP*W-1:0] y,
  input  logic vld_up,
  input  logic last_up,
  input  logic acc_up,
  output logic sad_rdy,
  output logic [W+clog2(NP)+ACC_BITS-1:0] sad_res,
  output logic sad_vld,
  input  logic rdy_dn,
  output logic zero,
  output logic sat,
  output logic sad_last
);

  localparam int L   = clog2(NP);
  localparam int RW  = rw_of(W, NP);
  localparam int AW  = aw_of(W, NP, ACC_BITS);
  localparam int TOT = lvl_off(W, NP, L + 1);
  localparam logic [31:0] MAXV =
    32'((64'd1 << AW) - 64'd1);

  logic [TOT-1:0] tq;
  sb_t            sb [L+1];
  logic [L:0]     v;
  sb_t            sl;
  logic [RW-1:0]  sum;
  logic           acc_only;
  logic           so_ld;
  logic           take;

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int N  = NP >> l;
    localparam int TW = W + l;
    localparam int O  = lvl_off(W, NP, l);
    logic [N*TW-1:0] d;
    sb_t             si;
    logic            dn;

    if (l == 0) begin : g_abs
      // per-lane absolute difference
      always_comb begin
        d = '0;
        for (int k = 0; k < NP; k++)
          d[k*W +: W] =
            (x[k*W +: W] > y[k*W +: W]) ?
            x[k*W +: W] - y[k*W +: W] :
            y[k*W +: W] - x[k*W +: W];
      end
      assign si = '{vld: vld_up,
                    acc: acc_up,
                    last: last_up};
    end else begin : g_add
      localparam int P  = lvl_off(W, NP, l - 1);
      localparam int PW = TW - 1;
      // pairwise sum of the previous level
      always_comb begin
        d = '0;
        for (int k = 0; k < N; k++)
          d[k*TW +: TW] =
            TW'(tq[P + 2*k*PW +: PW]) +
            TW'(tq[P + (2*k+1)*PW +: PW]);
      end
      assign si = sb[l-1];
    end

    if (l == L) begin : g_dl
      assign dn = take;
    end else begin : g_dm
      assign dn = take || !(&v[L:l+1]);
    end

    assign v[l] = sb[l].vld;

    sad_pipe_stage #(.DW(N*TW)) u_stg (
      .clk   (clk),
      .rst   (rst),
      .d     (d),
      .si    (si),
      .dn_ld (dn),
      .q     (tq[O +: N*TW]),
      .so    (sb[l])
    );
  end

  assign sl  = sb[L];
  assign sum = tq[TOT-RW +: RW];

  logic [AW-1:0] acc_q;
  logic          acc_sat;
  logic [AW-1:0] sum_x;
  logic [AW-1:0] tot;
  logic          ovf;
  logic [AW:0]   so_d;
  logic [AW:0]   so_q;
  sb_t           so_si;
  sb_t           so_sb;

  assign acc_only = sl.acc && !sl.last;
  assign so_ld    = !so_sb.vld || rdy_dn;
  assign take     = sl.vld && (acc_only || so_ld);
  assign sad_rdy  = !rst && (take || !(&v));

  assign sum_x = AW'(sum);
  assign tot   = AW'(sat_add(32'(acc_q),
                  32'(sum_x), MAXV));
  assign ovf   = sat_ovf(32'(acc_q),
                  32'(sum_x), MAXV);

  // result word: plain sum or closing block total
  always_comb begin
    so_d = {1'b0, sum_x};
    if (sl.acc) so_d = {acc_sat | ovf, tot};
  end

  assign so_si = '{vld: sl.vld && !acc_only,
                   acc: sl.acc,
                   last: sl.last};

  sad_pipe_stage #(.DW(AW+1)) u_so (
    .clk   (clk),
    .rst   (rst),
    .d     (so_d),
    .si    (so_si),
    .dn_ld (rdy_dn),
    .q     (so_q),
    .so    (so_sb)
  );

  // block accumulator, cleared when a block closes
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      acc_sat <= 1'b0;
    end else if (take && sl.acc) begin
      if (sl.last) begin
        acc_q   <= '0;
        acc_sat <= 1'b0;
      end else begin
        acc_q   <= tot;
        acc_sat <= acc_sat | ovf;
      end
    end
  end

  assign sad_res  = so_q[AW-1:0];
  assign sad_vld  = so_sb.vld;
  assign sat      = so_sb.vld && so_q[AW];
  assign sad_last = so_sb.acc && so_sb.last;
  assign zero     = so_sb.vld && (sad_res == '0);

endmodule

// File: doc/sad_pipe_n.md
Name: sad_pipe_n

Overview:
- Parametrised successor to the fixed two-pair SAD pipe.
- Computes the sum of absolute differences over NP lane pairs (x[k], y[k]) per beat, through a registered abs-diff stage, a pipelined adder tree and an output/accumulate stage.
- Valid/ready handshake on both sides with full backpressure.
- Adds a block-accumulate mode: per-beat SADs are summed until a last-flagged beat, then one saturating total is emitted.
- Sits between the pixel-fetch stage and the motion-search comparator.

Parameters:
- W, 8: lane width in bits (unsigned).
- NP, 2: number of lane pairs per beat; power of 2, 1 to 16.
- ACC_BITS, 8: extra accumulator headroom bits for block mode.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous reset, active-high.
- x, in, NP*W: lane k in bits [k*W +: W].
- y, in, NP*W: lane k in bits [k*W +: W].
- vld_up, in, 1: input beat valid.
- last_up, in, 1: final beat of a block (meaningful only when acc_up=1).
- acc_up, in, 1: beat mode; 0 = per-beat result, 1 = accumulate into the block.
- sad_rdy, out, 1: input ready.
- sad_res, out, RW+ACC_BITS: result, where RW = W+clog2(NP).
- sad_vld, out, 1: result valid.
- rdy_dn, in, 1: downstream ready.
- zero, out, 1: sad_res == 0.
- sat, out, 1: accumulated result saturated.
- sad_last, out, 1: result closes an accumulated block.

Behaviour:
- Clock and reset: single clock domain, clk. Reset rst is synchronous and active-high.
- Reset values: all stage valids 0, sad_vld=0, sad_res=0, zero=0, sat=0, sad_last=0, accumulator=0, acc_sat=0.
- Reset mid-operation: in-flight beats and the partial accumulation are discarded, with no output. sad_rdy is 0 during the rst cycle and 1 on the first cycle after.
- Input handshake: a beat transfers when vld_up & sad_rdy. Output handshake: a result transfers when sad_vld & rdy_dn.
- sad_vld, sad_res and flags hold stable until accepted.
- Stages, each one register with a valid bit:
  - S0: |x[k]-y[k]|, W bits each.
  - T1..TL: adder tree, L = clog2(NP), each level halving the term count and adding one bit.
  - SO: output/accumulate register.
  - When NP=1, L=0.
- Pipelining rule: stage i loads when its register is empty or stage i+1 loads in the same cycle. sad_rdy = stage-S0 load condition. The ready chain is combinational.
- Throughput: 1 beat/cycle with rdy_dn=1 and no bubbles.
- Latency: L+2 cycles from input transfer to sad_vld. NP=2 gives 3 cycles.
- acc_up and last_up travel with their beat through every stage.
- SO, beat with acc_up=0: sad_res = zero-extended tree sum; sad_last=0, sat=0. The accumulator is untouched, so an interleaved per-beat result does not disturb an open block.
- SO, beat with acc_up=1 and last_up=0:
  - acc += sum, saturating at 2^(RW+ACC_BITS)-1; set acc_sat on clamp.
  - No output is produced; SO stays empty.
- SO, beat with acc_up=1 and last_up=1:
  - sad_res = saturating acc + sum; sat = acc_sat or clamp on this add; sad_last=1.
  - Accumulator and acc_sat clear in the same cycle.
  - A single-beat block (first beat already last) is legal.
- Non-emitting accumulate beats consume SO without producing an output. They must not be blocked by a full SO that is draining: a beat may accumulate when SO holds a pending result.
- zero is computed from the registered sad_res.
- No ordering hazard: results exit in input order.

Decomposition:
- Shared package sad_pkg:
  - clog2 function.
  - Derived widths RW and AW.
  - Saturating-add function.
  - Per-stage sideband struct {vld, acc, last}.
- One natural sub-module, sad_pipe_stage: a parametrised-width register with valid/ready load logic. It is instantiated for S0, each tree level, and the SO data path.

Test Plan:
- Per-beat, NP=2, W=8, rdy_dn=1, x={1,3}, y={4,1}: sad_res=5 exactly 3 cycles after transfer, zero=0. Next beat x=y={7,7}: sad_res=0, zero=1.
- Streaming with random stalls: 80 beats with x0=i, x1=i+1, y0=3i, y1=2i; vld_up prob 0.75, rdy_dn prob 0.25. Outputs are in order and each equals |i-3i|+|i+1-2i|; no loss or duplication; sad_res stable while stalled.
- Block accumulate: 4 beats of acc_up=1 with sums 10, 20, 30, 40, last on the 4th. Exactly one output: 100, sad_last=1, sat=0. An interleaved acc_up=0 beat of sum 7 emits 7 without altering the total.
- Saturation: ACC_BITS=1, NP=2, W=8 (AW=10, max 1023). 5 accumulated beats of 255+255. Output is 1023 with sat=1; the next block starts from 0 and a 1-beat block of 2 gives 2 with sat=0.
- Reset mid-block: 2 accumulate beats, assert rst for 1 cycle, then a 1-beat block with sum 3. Output 3, no stale output, sad_rdy=1 the cycle after rst.
- NP=8 parameter sweep: all lanes with |x-y|=255. sad_res=2040 at latency 5; full throughput with rdy_dn tied to 1.
